// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of a single-cycle RV32I ALU: decodes one word at a time,
// reads operands from a local 32-entry register file, then retires the ALU result.
module alu_issue_ctrl #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               ALU_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [31:0]             instr,
  input  logic                    rf_wr_en,
  input  logic [4:0]              rf_wr_idx,
  input  logic [WIDTH-1:0]        rf_wr_data,
  output logic [WIDTH-1:0]        pc,
  output logic signed [WIDTH-1:0] RS1,
  output logic signed [WIDTH-1:0] RS2,
  output logic [6:0]              opcode,
  output logic [2:0]              Funct3,
  output logic [6:0]              Funct7,
  output logic [11:0]             Imm_reg,
  output logic [4:0]              Shamt,
  input  logic [WIDTH-1:0]        RD,
  input  logic [WIDTH-1:0]        Mem_addr,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd_idx,
  output logic [WIDTH-1:0]        wb_data,
  output logic                    mem_valid,
  output logic [WIDTH-1:0]        mem_addr,
  output logic                    mem_we,
  output logic                    illegal
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_lat_cnt;
  logic [WIDTH-1:0]   r_fetch_pc;
  logic [4:0]         r_rd_idx;
  logic [WIDTH-1:0]   r_rf [32];

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_is_r, w_is_i, w_is_ld, w_is_st, w_is_legal;
  logic [6:0]  w_f7;
  logic [11:0] w_imm;
  logic        w_accept, w_issue, w_last;
  logic        w_ret_mem, w_wb_fire, w_pre_fire;

  assign w_op       = instr[6:0];
  assign w_f3       = instr[14:12];
  assign w_is_r     = (w_op == OP_R);
  assign w_is_i     = (w_op == OP_I);
  assign w_is_ld    = (w_op == OP_LD);
  assign w_is_st    = (w_op == OP_ST);
  assign w_is_legal = w_is_r | w_is_i | w_is_ld | w_is_st;

  // Funct7 only carries meaning for R-type and the I-type shift encodings.
  assign w_f7 = (w_is_r || (w_is_i && (w_f3 == 3'b001 || w_f3 == 3'b101))) ? instr[31:25] : 7'd0;

  always_comb begin
    w_imm = 12'd0;
    if (w_is_i || w_is_ld) begin
      w_imm = instr[31:20];
    end else if (w_is_st) begin
      w_imm = {instr[31:25], instr[11:7]};
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign w_ret_mem   = (opcode == OP_LD) || (opcode == OP_ST);
  assign w_wb_fire   = w_last && !w_ret_mem && (r_rd_idx != 5'd0);
  assign w_pre_fire  = instr_ready && rf_wr_en && (rf_wr_idx != 5'd0);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_accept = 1'b1;
          if (w_is_legal) begin
            w_issue      = 1'b1;
            w_state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (r_lat_cnt == CNT_W'(ALU_LATENCY - 1)) begin
          w_last       = 1'b1;
          w_state_next = S_WB;
        end
      end
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      pc         <= RESET_PC;
      r_lat_cnt  <= '0;
      r_rd_idx   <= 5'd0;
      RS1        <= '0;
      RS2        <= '0;
      opcode     <= 7'd0;
      Funct3     <= 3'd0;
      Funct7     <= 7'd0;
      Imm_reg    <= 12'd0;
      Shamt      <= 5'd0;
      wb_valid   <= 1'b0;
      wb_rd_idx  <= 5'd0;
      wb_data    <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      mem_valid <= 1'b0;
      illegal   <= w_accept && !w_is_legal;
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + WIDTH'(4);
      end
      if (w_issue) begin
        pc        <= r_fetch_pc;
        RS1       <= r_rf[instr[19:15]];
        RS2       <= r_rf[instr[24:20]];
        opcode    <= w_op;
        Funct3    <= w_f3;
        Funct7    <= w_f7;
        Imm_reg   <= w_imm;
        Shamt     <= instr[24:20];
        r_rd_idx  <= instr[11:7];
        r_lat_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
        r_lat_cnt <= r_lat_cnt + CNT_W'(1);
      end
      if (w_last && w_ret_mem) begin
        mem_valid <= 1'b1;
        mem_addr  <= Mem_addr;
        mem_we    <= (opcode == OP_ST);
      end
      if (w_wb_fire) begin
        wb_valid  <= 1'b1;
        wb_rd_idx <= r_rd_idx;
        wb_data   <= RD;
      end
    end
  end

  // Entry 0 is never written, so x0 always reads back as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wb_fire) begin
      r_rf[r_rd_idx] <= RD;
    end else if (w_pre_fire) begin
      r_rf[rf_wr_idx] <= rf_wr_data;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: transaction-level model of issue/retire timing and register
// contents, directed literal checks plus randomized instruction traffic.
module tb_alu_issue_ctrl;

  localparam int          L   = 3;
  localparam logic [31:0] RPC = 32'hFFFF_FFF0;
  localparam logic [6:0]  OP_R  = 7'b0110011;
  localparam logic [6:0]  OP_I  = 7'b0010011;
  localparam logic [6:0]  OP_LD = 7'b0000011;
  localparam logic [6:0]  OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        rf_wr_en = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [4:0]  rf_wr_idx = 5'd0;
  logic [31:0] rf_wr_data = 32'd0;
  logic [31:0] RD = 32'd0;
  logic [31:0] Mem_addr = 32'd0;

  logic               instr_ready;
  logic [31:0]        pc;
  logic signed [31:0] RS1, RS2;
  logic [6:0]         opcode, Funct7;
  logic [2:0]         Funct3;
  logic [11:0]        Imm_reg;
  logic [4:0]         Shamt, wb_rd_idx;
  logic               wb_valid, mem_valid, mem_we, illegal;
  logic [31:0]        wb_data, mem_addr;

  alu_issue_ctrl #(.WIDTH(32), .RESET_PC(RPC), .ALU_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data), .pc(pc),
    .RS1(RS1), .RS2(RS2), .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7),
    .Imm_reg(Imm_reg), .Shamt(Shamt), .RD(RD), .Mem_addr(Mem_addr),
    .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txn = 0;
  logic chk_en = 1'b0;

  // Model state: architectural registers, fetch pc and the expected value of every output.
  logic [31:0] m_rf [32];
  logic [31:0] m_fpc;
  logic [31:0] exp_pc, exp_rs1, exp_rs2, exp_wb_data, exp_mem_addr;
  logic [6:0]  exp_op, exp_f7;
  logic [2:0]  exp_f3;
  logic [11:0] exp_imm;
  logic [4:0]  exp_shamt, exp_wb_idx;
  logic        exp_ready, exp_wb_valid, exp_mem_valid, exp_mem_we, exp_illegal;

  logic [31:0] cap_pc, cap_rs1, cap_rs2, cap_wbd, cap_mema;
  logic [6:0]  cap_op, cap_f7;
  logic [2:0]  cap_f3;
  logic [11:0] cap_imm;
  logic [4:0]  cap_shamt, cap_wbi;
  logic        cap_wbv, cap_memv, cap_memwe, cap_ill;

  function automatic logic m_legal(input logic [31:0] w);
    return (w[6:0] == OP_R) || (w[6:0] == OP_I) || (w[6:0] == OP_LD) || (w[6:0] == OP_ST);
  endfunction

  function automatic logic [6:0] m_f7(input logic [31:0] w);
    if (w[6:0] == OP_R) return w[31:25];
    if (w[6:0] == OP_I && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) return w[31:25];
    return 7'd0;
  endfunction

  function automatic logic [11:0] m_imm(input logic [31:0] w);
    if (w[6:0] == OP_I || w[6:0] == OP_LD) return w[31:20];
    if (w[6:0] == OP_ST) return {w[31:25], w[11:7]};
    return 12'd0;
  endfunction

  function automatic logic [31:0] rand_word(input int t);
    logic [31:0] w;
    logic [6:0]  o;
    w = $urandom;
    case (t)
      0: begin w[6:0] = OP_R; w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
      1: w[6:0] = OP_I;
      2: w[6:0] = OP_LD;
      3: w[6:0] = OP_ST;
      default: begin
        do o = 7'($urandom); while (o == OP_R || o == OP_I || o == OP_LD || o == OP_ST);
        w[6:0] = o;
      end
    endcase
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic compare_all();
    chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
    chk("pc", pc, exp_pc);
    chk("RS1", RS1, exp_rs1);
    chk("RS2", RS2, exp_rs2);
    chk("opcode", 32'(opcode), 32'(exp_op));
    chk("Funct3", 32'(Funct3), 32'(exp_f3));
    chk("Funct7", 32'(Funct7), 32'(exp_f7));
    chk("Imm_reg", 32'(Imm_reg), 32'(exp_imm));
    chk("Shamt", 32'(Shamt), 32'(exp_shamt));
    chk("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
    chk("mem_valid", 32'(mem_valid), 32'(exp_mem_valid));
    chk("illegal", 32'(illegal), 32'(exp_illegal));
    if (exp_wb_valid) begin
      chk("wb_rd_idx", 32'(wb_rd_idx), 32'(exp_wb_idx));
      chk("wb_data", wb_data, exp_wb_data);
    end
    if (exp_mem_valid) begin
      chk("mem_addr", mem_addr, exp_mem_addr);
      chk("mem_we", 32'(mem_we), 32'(exp_mem_we));
    end
  endtask

  // One clock: compare on the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    if (chk_en) compare_all();
    @(posedge clk);
    #1;
    exp_wb_valid  = 1'b0;
    exp_mem_valid = 1'b0;
    exp_illegal   = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_fpc = RPC; exp_pc = RPC;
    exp_rs1 = 0; exp_rs2 = 0; exp_op = 0; exp_f3 = 0; exp_f7 = 0; exp_imm = 0; exp_shamt = 0;
    exp_ready = 1'b1; exp_wb_valid = 0; exp_mem_valid = 0; exp_illegal = 0;
    exp_wb_idx = 0; exp_wb_data = 0; exp_mem_addr = 0; exp_mem_we = 0;
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] data);
    rf_wr_en = 1'b1; rf_wr_idx = idx; rf_wr_data = data;
    step();
    rf_wr_en = 1'b0;
    if (idx != 5'd0) m_rf[idx] = data;
  endtask

  task automatic do_instr(input logic [31:0] w, input logic pre_en, input logic [4:0] pidx,
                          input logic [31:0] pdata, input logic noise, input logic fix,
                          input logic [31:0] fix_rd, input logic [31:0] fix_adr, input int abort_at);
    logic [31:0] s1, s2, rdv, adv;
    logic [6:0]  op;
    op = w[6:0];
    s1 = m_rf[w[19:15]];
    s2 = m_rf[w[24:20]];
    instr = w; instr_valid = 1'b1;
    rf_wr_en = pre_en; rf_wr_idx = pidx; rf_wr_data = pdata;
    cap_wbv = 1'b0; cap_memv = 1'b0;
    step();
    instr_valid = 1'b0; rf_wr_en = 1'b0;
    if (pre_en && pidx != 5'd0) m_rf[pidx] = pdata;
    m_fpc = m_fpc + 32'd4;
    txn++;
    if (!m_legal(w)) begin
      exp_illegal = 1'b1;
      cap_ill = illegal;
      $display("txn %0d word=%h illegal", txn, w);
      return;
    end
    exp_pc = m_fpc - 32'd4;
    exp_rs1 = s1; exp_rs2 = s2; exp_op = op; exp_f3 = w[14:12];
    exp_f7 = m_f7(w); exp_imm = m_imm(w); exp_shamt = w[24:20]; exp_ready = 1'b0;
    cap_pc = pc; cap_rs1 = RS1; cap_rs2 = RS2; cap_op = opcode; cap_f3 = Funct3;
    cap_f7 = Funct7; cap_imm = Imm_reg; cap_shamt = Shamt; cap_ill = illegal;
    rdv = 0; adv = 0;
    for (int k = 1; k <= L; k++) begin
      if (noise) begin
        instr_valid = 1'($urandom_range(0, 1)); instr = $urandom;
        rf_wr_en = 1'($urandom_range(0, 1)); rf_wr_idx = 5'($urandom); rf_wr_data = $urandom;
      end
      rdv = (fix && k == L) ? fix_rd : $urandom;
      adv = (fix && k == L) ? fix_adr : $urandom;
      RD = rdv; Mem_addr = adv;
      if (k == abort_at) rst = 1'b0;
      step();
      if (k == abort_at) begin
        rst = 1'b1; instr_valid = 1'b0; rf_wr_en = 1'b0;
        model_reset();
        $display("txn %0d word=%h aborted by reset", txn, w);
        return;
      end
    end
    instr_valid = 1'b0; rf_wr_en = 1'b0;
    if (op == OP_LD || op == OP_ST) begin
      exp_mem_valid = 1'b1; exp_mem_addr = adv; exp_mem_we = (op == OP_ST);
    end else if (w[11:7] != 5'd0) begin
      exp_wb_valid = 1'b1; exp_wb_idx = w[11:7]; exp_wb_data = rdv;
      m_rf[w[11:7]] = rdv;
    end
    cap_wbv = wb_valid; cap_wbi = wb_rd_idx; cap_wbd = wb_data;
    cap_memv = mem_valid; cap_mema = mem_addr; cap_memwe = mem_we;
    step();
    exp_ready = 1'b1;
    $display("txn %0d word=%h pc=%h rs1=%h rs2=%h", txn, w, exp_pc, exp_rs1, exp_rs2);
  endtask

  task automatic run(input logic [31:0] w);
    do_instr(w, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low for two edges.
    rst = 1'b0;
    step();
    model_reset();
    chk_en = 1'b1;
    step();
    rst = 1'b1;
    chk("rst_pc", pc, RPC);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_RS1", RS1, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd_idx", 32'(wb_rd_idx), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);

    // ADD x3,x1,x2 with x1=5, x2=7.
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    do_instr(32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd12, 32'd0, 0);
    chk("t2_pc", cap_pc, RPC);
    chk("t2_opcode", 32'(cap_op), 32'h33);
    chk("t2_RS1", cap_rs1, 32'd5);
    chk("t2_RS2", cap_rs2, 32'd7);
    chk("t2_Funct7", 32'(cap_f7), 32'd0);
    chk("t2_wb_valid", 32'(cap_wbv), 32'd1);
    chk("t2_wb_rd_idx", 32'(cap_wbi), 32'd3);
    chk("t2_wb_data", cap_wbd, 32'd12);

    // SRAI x5,x1,3.
    run(32'h4030D293);
    chk("t3_pc", cap_pc, 32'hFFFF_FFF4);
    chk("t3_Funct7", 32'(cap_f7), 32'h20);
    chk("t3_Shamt", 32'(cap_shamt), 32'd3);
    chk("t3_Imm_reg", 32'(cap_imm), 32'h403);
    chk("t3_Funct3", 32'(cap_f3), 32'd5);

    // SW x2,8(x1) with effective address 13.
    do_instr(32'h0020A423, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd99, 32'd13, 0);
    chk("t4_Imm_reg", 32'(cap_imm), 32'd8);
    chk("t4_mem_valid", 32'(cap_memv), 32'd1);
    chk("t4_mem_we", 32'(cap_memwe), 32'd1);
    chk("t4_mem_addr", cap_mema, 32'd13);
    chk("t4_wb_valid", 32'(cap_wbv), 32'd0);

    // ADDI x0,x1,1 has no writeback; x0 preload discarded; illegal word skipped.
    run(32'h00108013);
    chk("t5_addi_x0_wb_valid", 32'(cap_wbv), 32'd0);
    preload(5'd0, 32'd99);
    run(32'h00000233);
    chk("t5_wrap_pc", cap_pc, 32'd0);
    chk("t5_x0_RS1", cap_rs1, 32'd0);
    chk("t5_x0_RS2", cap_rs2, 32'd0);
    run(32'h0000007F);
    chk("t5_illegal", 32'(cap_ill), 32'd1);

    // Preload in the accept cycle: operand reads the old value, next instruction the new one.
    do_instr(32'h006303B3, 1'b1, 5'd6, 32'h55, 1'b0, 1'b0, 32'd0, 32'd0, 0);
    chk("pre_same_cycle_pc", cap_pc, 32'd8);
    chk("pre_same_cycle_RS1", cap_rs1, 32'd0);
    run(32'h00030433);
    chk("pre_next_RS1", cap_rs1, 32'h55);

    // Randomized traffic, with busy-time noise on instr_valid and the preload port.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      do_instr(rand_word($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 5'($urandom),
               $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'd0, 32'd0, 0);
    end
    repeat (2) step();

    // Reset in the middle of ISSUE aborts the instruction.
    do_instr(32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2);
    chk("t6_ready", 32'(instr_ready), 32'd1);
    chk("t6_pc", pc, RPC);
    repeat (L + 2) step();

    // pc wraps from 0xFFFFFFFC to 0; regfile cleared by the reset.
    run(32'h0000007F);
    run(32'h0000007F);
    run(32'h0000007F);
    run(32'h002081B3);
    chk("t6_pc_fffffffc", cap_pc, 32'hFFFF_FFFC);
    chk("t6_cleared_RS1", cap_rs1, 32'd0);
    run(32'h00100093);
    chk("t6_pc_wrap", cap_pc, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
